// File: rtl/reservation_station.sv
// Reservation station: holds dispatched ops until both operands are valid, then issues one per cycle to an
// internal ALU. Define RS_AGE_SELECT_EN to issue the oldest ready entry instead of the lowest-index one.
module reservation_station #(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  op_in,
   input  logic [2:0]  target_in,
   input  logic [31:0] value1_in,
   input  logic [31:0] value2_in,
   input  logic [2:0]  query1_in,
   input  logic [2:0]  query2_in,
   input  logic [2:0]  mem_num,
   input  logic [31:0] mem_value,
   output logic        rs_full,
   output logic [2:0]  alu_num,
   output logic [31:0] alu_value
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   localparam logic [4:0] OP_ADD  = 5'b00000;
   localparam logic [4:0] OP_AND  = 5'b00001;
   localparam logic [4:0] OP_OR   = 5'b00010;
   localparam logic [4:0] OP_SLL  = 5'b00011;
   localparam logic [4:0] OP_SRL  = 5'b00100;
   localparam logic [4:0] OP_SLT  = 5'b00101;
   localparam logic [4:0] OP_SLTU = 5'b00110;
   localparam logic [4:0] OP_SRA  = 5'b00111;
   localparam logic [4:0] OP_SUB  = 5'b01000;
   localparam logic [4:0] OP_XOR  = 5'b01001;
   localparam logic [4:0] OP_BEQ  = 5'b01010;
   localparam logic [4:0] OP_BGE  = 5'b01011;
   localparam logic [4:0] OP_BNE  = 5'b01100;
   localparam logic [4:0] OP_BGEU = 5'b01101;
   localparam logic [4:0] OP_BLT  = 5'b11010;
   localparam logic [4:0] OP_BLTU = 5'b11011;
   localparam logic [4:0] OP_JALR = 5'b10001;

   function automatic logic op_legal(input logic [4:0] op);
      case (op)
         OP_ADD, OP_AND, OP_OR, OP_SLL, OP_SRL, OP_SLT, OP_SLTU, OP_SRA, OP_SUB,
         OP_XOR, OP_BEQ, OP_BGE, OP_BNE, OP_BGEU, OP_BLT, OP_BLTU, OP_JALR:
            op_legal = 1'b1;
         default:
            op_legal = 1'b0;
      endcase
   endfunction

   function automatic logic [31:0] alu_compute(input logic [4:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
      logic [4:0] sh;
      sh = b[4:0];
      case (op)
         OP_ADD:  alu_compute = a + b;
         OP_AND:  alu_compute = a & b;
         OP_OR:   alu_compute = a | b;
         OP_SLL:  alu_compute = a << sh;
         OP_SRL:  alu_compute = a >> sh;
         OP_SLT:  alu_compute = {31'd0, ($signed(a) < $signed(b))};
         OP_SLTU: alu_compute = {31'd0, (a < b)};
         OP_SRA:  alu_compute = $unsigned($signed(a) >>> sh);
         OP_SUB:  alu_compute = a - b;
         OP_XOR:  alu_compute = a ^ b;
         OP_BEQ:  alu_compute = {31'd0, (a == b)};
         OP_BGE:  alu_compute = {31'd0, ($signed(a) >= $signed(b))};
         OP_BNE:  alu_compute = {31'd0, (a != b)};
         OP_BGEU: alu_compute = {31'd0, (a >= b)};
         OP_BLT:  alu_compute = {31'd0, ($signed(a) < $signed(b))};
         OP_BLTU: alu_compute = {31'd0, (a < b)};
         OP_JALR: alu_compute = (a + b) & 32'hFFFF_FFFE;
         default: alu_compute = 32'd0;
      endcase
   endfunction

   // A pending operand grabs a broadcast value; the load bus wins when both buses carry the same tag.
   function automatic logic [34:0] wake_operand(input logic [2:0] q, input logic [31:0] v,
                                                input logic [2:0] mn, input logic [31:0] mv,
                                                input logic [2:0] an, input logic [31:0] av);
      if (q != 3'd0 && q == mn) begin
         wake_operand = {3'd0, mv};
      end else if (q != 3'd0 && q == an) begin
         wake_operand = {3'd0, av};
      end else begin
         wake_operand = {q, v};
      end
   endfunction

   logic [DEPTH-1:0] valid_r;
   logic [DEPTH-1:0] valid_nxt_s;
   logic [4:0]       op_r      [DEPTH];
   logic [4:0]       op_nxt_s  [DEPTH];
   logic [2:0]       tag_r     [DEPTH];
   logic [2:0]       tag_nxt_s [DEPTH];
   logic [2:0]       q1_r      [DEPTH];
   logic [2:0]       q1_nxt_s  [DEPTH];
   logic [2:0]       q2_r      [DEPTH];
   logic [2:0]       q2_nxt_s  [DEPTH];
   logic [31:0]      v1_r      [DEPTH];
   logic [31:0]      v1_nxt_s  [DEPTH];
   logic [31:0]      v2_r      [DEPTH];
   logic [31:0]      v2_nxt_s  [DEPTH];

   logic [DEPTH-1:0] ready_s;
   logic             issue_s;
   logic [IDX_W-1:0] issue_idx_s;
   logic [IDX_W-1:0] free_idx_s;
   logic             accept_s;
   logic [31:0]      result_s;
   logic [2:0]       alu_num_r;
   logic [31:0]      alu_value_r;

   assign rs_full   = &valid_r;
   assign accept_s  = op_legal(op_in) && !rs_full;
   assign alu_num   = alu_num_r;
   assign alu_value = alu_value_r;
   assign result_s  = alu_compute(op_r[issue_idx_s], v1_r[issue_idx_s], v2_r[issue_idx_s]);

   // Readiness of each entry and the lowest free slot for the next dispatch.
   always_comb begin
      free_idx_s = {IDX_W{1'b0}};
      for (int i = DEPTH - 1; i >= 0; i--) begin
         ready_s[i] = valid_r[i] && (q1_r[i] == 3'd0) && (q2_r[i] == 3'd0);
         free_idx_s = valid_r[i] ? free_idx_s : IDX_W'(i);
      end
   end

`ifdef RS_AGE_SELECT_EN
   // age_r counts the valid entries older than this one, so 0 marks the oldest.
   logic [2:0] age_r     [DEPTH];
   logic [2:0] age_nxt_s [DEPTH];
   logic [2:0] best_age_s;
   logic [3:0] valid_cnt_s;
   logic [2:0] new_age_s;
   logic       take_s;

   // Oldest ready entry wins issue.
   always_comb begin
      issue_s     = 1'b0;
      issue_idx_s = {IDX_W{1'b0}};
      best_age_s  = 3'd7;
      take_s      = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         take_s      = ready_s[i] && (!issue_s || (age_r[i] < best_age_s));
         issue_idx_s = take_s ? IDX_W'(i) : issue_idx_s;
         best_age_s  = take_s ? age_r[i] : best_age_s;
         issue_s     = issue_s | take_s;
      end
   end

   // Age bookkeeping: newcomers rank behind survivors, younger entries close the gap left by an issue.
   always_comb begin
      valid_cnt_s = 4'd0;
      for (int i = 0; i < DEPTH; i++) begin
         valid_cnt_s = valid_cnt_s + {3'd0, valid_r[i]};
      end
      new_age_s = valid_cnt_s[2:0] - {2'd0, issue_s};
      for (int i = 0; i < DEPTH; i++) begin
         if (accept_s && free_idx_s == IDX_W'(i)) begin
            age_nxt_s[i] = new_age_s;
         end else if (issue_s && age_r[i] > age_r[issue_idx_s]) begin
            age_nxt_s[i] = age_r[i] - 3'd1;
         end else begin
            age_nxt_s[i] = age_r[i];
         end
      end
   end

   // Age registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            age_r[i] <= 3'd0;
         end
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            age_r[i] <= age_nxt_s[i];
         end
      end
   end
`else
   // Lowest-index ready entry wins issue.
   always_comb begin
      issue_s     = |ready_s;
      issue_idx_s = {IDX_W{1'b0}};
      for (int i = DEPTH - 1; i >= 0; i--) begin
         issue_idx_s = ready_s[i] ? IDX_W'(i) : issue_idx_s;
      end
   end
`endif

   // Entry next state: dispatch write with same-edge wakeup, operand wakeup, and release on issue.
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         op_nxt_s[i]  = op_r[i];
         tag_nxt_s[i] = tag_r[i];
         q1_nxt_s[i]  = q1_r[i];
         q2_nxt_s[i]  = q2_r[i];
         v1_nxt_s[i]  = v1_r[i];
         v2_nxt_s[i]  = v2_r[i];
         valid_nxt_s[i] = valid_r[i] & ~(issue_s && issue_idx_s == IDX_W'(i));
         if (accept_s && free_idx_s == IDX_W'(i)) begin
            valid_nxt_s[i] = 1'b1;
            op_nxt_s[i]    = op_in;
            tag_nxt_s[i]   = target_in;
            {q1_nxt_s[i], v1_nxt_s[i]} = wake_operand(query1_in, value1_in, mem_num, mem_value,
                                                      alu_num_r, alu_value_r);
            {q2_nxt_s[i], v2_nxt_s[i]} = wake_operand(query2_in, value2_in, mem_num, mem_value,
                                                      alu_num_r, alu_value_r);
         end else if (valid_r[i]) begin
            {q1_nxt_s[i], v1_nxt_s[i]} = wake_operand(q1_r[i], v1_r[i], mem_num, mem_value,
                                                      alu_num_r, alu_value_r);
            {q2_nxt_s[i], v2_nxt_s[i]} = wake_operand(q2_r[i], v2_r[i], mem_num, mem_value,
                                                      alu_num_r, alu_value_r);
         end else begin
            valid_nxt_s[i] = 1'b0;
         end
      end
   end

   // Entry storage.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid_r <= {DEPTH{1'b0}};
         for (int i = 0; i < DEPTH; i++) begin
            op_r[i]  <= 5'd0;
            tag_r[i] <= 3'd0;
            q1_r[i]  <= 3'd0;
            q2_r[i]  <= 3'd0;
            v1_r[i]  <= 32'd0;
            v2_r[i]  <= 32'd0;
         end
      end else begin
         valid_r <= valid_nxt_s;
         for (int i = 0; i < DEPTH; i++) begin
            op_r[i]  <= op_nxt_s[i];
            tag_r[i] <= tag_nxt_s[i];
            q1_r[i]  <= q1_nxt_s[i];
            q2_r[i]  <= q2_nxt_s[i];
            v1_r[i]  <= v1_nxt_s[i];
            v2_r[i]  <= v2_nxt_s[i];
         end
      end
   end

   // Result register; the value persists across idle cycles while the tag drops to zero.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         alu_num_r   <= 3'd0;
         alu_value_r <= 32'd0;
      end else if (issue_s) begin
         alu_num_r   <= tag_r[issue_idx_s];
         alu_value_r <= result_s;
      end else begin
         alu_num_r   <= 3'd0;
      end
   end

endmodule

// File: tb/tb_reservation_station.sv
// Directed self-checking bench for reservation_station (DEPTH 4); expected issue order follows
// RS_AGE_SELECT_EN when the bench is built with that macro.
module tb_reservation_station;

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  op_in;
   logic [2:0]  target_in;
   logic [31:0] value1_in;
   logic [31:0] value2_in;
   logic [2:0]  query1_in;
   logic [2:0]  query2_in;
   logic [2:0]  mem_num;
   logic [31:0] mem_value;
   logic        rs_full;
   logic [2:0]  alu_num;
   logic [31:0] alu_value;

   int n_checks = 0;
   int n_fail   = 0;

   reservation_station #(.DEPTH(4)) dut (
      .clk(clk), .rst(rst), .op_in(op_in), .target_in(target_in),
      .value1_in(value1_in), .value2_in(value2_in), .query1_in(query1_in), .query2_in(query2_in),
      .mem_num(mem_num), .mem_value(mem_value), .rs_full(rs_full),
      .alu_num(alu_num), .alu_value(alu_value)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      op_in     = 5'b11111;
      target_in = 3'd0;
      value1_in = 32'd0;
      value2_in = 32'd0;
      query1_in = 3'd0;
      query2_in = 3'd0;
      mem_num   = 3'd0;
      mem_value = 32'd0;
   endtask

   task automatic drive(input logic [4:0] op, input logic [2:0] tag, input logic [31:0] v1,
                        input logic [31:0] v2, input logic [2:0] q1, input logic [2:0] q2);
      op_in     = op;
      target_in = tag;
      value1_in = v1;
      value2_in = v2;
      query1_in = q1;
      query2_in = q2;
   endtask

   logic [4:0]  t_op  [14] = '{5'b00011, 5'b00100, 5'b00111, 5'b00101, 5'b00110, 5'b01000, 5'b01001,
                               5'b00001, 5'b00010, 5'b01010, 5'b01100, 5'b01011, 5'b01101, 5'b00000};
   logic [31:0] t_a   [14] = '{32'h1, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                               32'h0, 32'hF0F0_F0F0, 32'hF0F0_F0F0, 32'hF0F0_F0F0, 32'h5, 32'h5,
                               32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
   logic [31:0] t_b   [14] = '{32'd33, 32'd31, 32'd4, 32'h1, 32'h1, 32'h1, 32'hFF00_FF00,
                               32'hFF00_FF00, 32'hFF00_FF00, 32'h5, 32'h5, 32'h1, 32'h1, 32'h2};
   logic [31:0] t_exp [14] = '{32'h2, 32'h1, 32'hF800_0000, 32'h1, 32'h0, 32'hFFFF_FFFF, 32'h0FF0_0FF0,
                               32'hF000_F000, 32'hFFF0_FFF0, 32'h1, 32'h0, 32'h0, 32'h1, 32'h1};

   logic [2:0]  first_tag;
   logic [2:0]  second_tag;
   logic [31:0] first_val;
   logic [31:0] second_val;

   initial begin
      rst = 1'b0;
      idle();
      #12;
      check_eq("reset_alu_num", {29'd0, alu_num}, 32'd0);
      check_eq("reset_alu_value", alu_value, 32'd0);
      check_eq("reset_rs_full", {31'd0, rs_full}, 32'd0);
      step();
      rst = 1'b1;

      // ADD with both operands ready
      drive(5'b00000, 3'd3, 32'd5, 32'd7, 3'd0, 3'd0);
      step();
      idle();
      check_eq("add_not_yet", {29'd0, alu_num}, 32'd0);
      step();
      check_eq("add_num", {29'd0, alu_num}, 32'd3);
      check_eq("add_value", alu_value, 32'd12);
      step();
      check_eq("add_idle_num", {29'd0, alu_num}, 32'd0);
      check_eq("add_hold_value", alu_value, 32'd12);

      // SUB waiting on a load
      drive(5'b01000, 3'd2, 32'hDEAD, 32'd1, 3'd5, 3'd0);
      step();
      idle();
      step();
      mem_num   = 3'd5;
      mem_value = 32'd10;
      step();
      idle();
      check_eq("sub_wake_edge", {29'd0, alu_num}, 32'd0);
      step();
      check_eq("sub_num", {29'd0, alu_num}, 32'd2);
      check_eq("sub_value", alu_value, 32'd9);

      // forwarding from the registered ALU result into a dispatch on the same edge
      drive(5'b00000, 3'd1, 32'd3, 32'd4, 3'd0, 3'd0);
      step();
      idle();
      step();
      check_eq("fwd_src_num", {29'd0, alu_num}, 32'd1);
      drive(5'b00000, 3'd2, 32'd0, 32'd10, 3'd1, 3'd0);
      step();
      idle();
      step();
      check_eq("fwd_alu_num", {29'd0, alu_num}, 32'd2);
      check_eq("fwd_alu_value", alu_value, 32'd17);

      // load bus beats ALU bus on a tag collision
      drive(5'b00000, 3'd1, 32'd3, 32'd4, 3'd0, 3'd0);
      step();
      idle();
      step();
      drive(5'b00000, 3'd2, 32'd0, 32'd10, 3'd1, 3'd0);
      mem_num   = 3'd1;
      mem_value = 32'd50;
      step();
      idle();
      step();
      check_eq("tie_value", alu_value, 32'd60);

      // BLT, BLTU, JALR back to back
      drive(5'b11010, 3'd1, 32'hFFFF_FFFF, 32'd1, 3'd0, 3'd0);
      step();
      drive(5'b11011, 3'd2, 32'hFFFF_FFFF, 32'd1, 3'd0, 3'd0);
      step();
      check_eq("blt_num", {29'd0, alu_num}, 32'd1);
      check_eq("blt_value", alu_value, 32'd1);
      drive(5'b10001, 3'd3, 32'h1001, 32'd4, 3'd0, 3'd0);
      step();
      idle();
      check_eq("bltu_num", {29'd0, alu_num}, 32'd2);
      check_eq("bltu_value", alu_value, 32'd0);
      step();
      check_eq("jalr_num", {29'd0, alu_num}, 32'd3);
      check_eq("jalr_value", alu_value, 32'h1004);

      // operation table
      for (int i = 0; i < 14; i++) begin
         drive(t_op[i], 3'((i % 7) + 1), t_a[i], t_b[i], 3'd0, 3'd0);
         step();
         idle();
         step();
         check_eq($sformatf("op%0d_num", i), {29'd0, alu_num}, 32'((i % 7) + 1));
         check_eq($sformatf("op%0d_value", i), alu_value, t_exp[i]);
      end

      // unsupported opcodes write nothing
      drive(5'b01110, 3'd4, 32'd1, 32'd1, 3'd0, 3'd0);
      step();
      drive(5'b11111, 3'd5, 32'd1, 32'd1, 3'd0, 3'd0);
      step();
      idle();
      check_eq("illegal_a_num", {29'd0, alu_num}, 32'd0);
      step();
      check_eq("illegal_b_num", {29'd0, alu_num}, 32'd0);

      // dispatch woken by the load bus on its own edge
      drive(5'b00000, 3'd5, 32'd0, 32'd1, 3'd4, 3'd0);
      mem_num   = 3'd4;
      mem_value = 32'd20;
      step();
      idle();
      step();
      check_eq("same_edge_num", {29'd0, alu_num}, 32'd5);
      check_eq("same_edge_value", alu_value, 32'd21);

      // fill, drop, drain
      for (int i = 0; i < 4; i++) begin
         drive(5'b00000, 3'(i + 1), 32'd0, 32'(i + 1), 3'd6, 3'd0);
         step();
      end
      check_eq("full_set", {31'd0, rs_full}, 32'd1);
      drive(5'b00000, 3'd5, 32'd1, 32'd1, 3'd0, 3'd0);
      step();
      idle();
      check_eq("full_hold", {31'd0, rs_full}, 32'd1);
      check_eq("full_no_issue", {29'd0, alu_num}, 32'd0);
      mem_num   = 3'd6;
      mem_value = 32'd100;
      step();
      idle();
      check_eq("drain_wake_edge", {29'd0, alu_num}, 32'd0);
      for (int i = 0; i < 4; i++) begin
         step();
         check_eq($sformatf("drain%0d_num", i), {29'd0, alu_num}, 32'(i + 1));
         check_eq($sformatf("drain%0d_value", i), alu_value, 32'(101 + i));
      end
      check_eq("drain_not_full", {31'd0, rs_full}, 32'd0);
      step();
      check_eq("drain_dropped", {29'd0, alu_num}, 32'd0);

      // reset with three waiting entries
      for (int i = 0; i < 3; i++) begin
         drive(5'b00000, 3'(i + 1), 32'd0, 32'd1, 3'd7, 3'd0);
         step();
      end
      idle();
      rst = 1'b0;
      #2;
      check_eq("midrst_num", {29'd0, alu_num}, 32'd0);
      check_eq("midrst_value", alu_value, 32'd0);
      check_eq("midrst_full", {31'd0, rs_full}, 32'd0);
      step();
      rst = 1'b1;
      mem_num   = 3'd7;
      mem_value = 32'd9;
      step();
      idle();
      step();
      check_eq("postrst_stale0", {29'd0, alu_num}, 32'd0);
      step();
      check_eq("postrst_stale1", {29'd0, alu_num}, 32'd0);
      drive(5'b00000, 3'd4, 32'd1, 32'd1, 3'd0, 3'd0);
      step();
      idle();
      step();
      check_eq("postrst_num", {29'd0, alu_num}, 32'd4);
      check_eq("postrst_value", alu_value, 32'd2);

      // issue order: slot 2 holds an older entry than a fresh slot-0 entry
      drive(5'b00000, 3'd1, 32'd0, 32'd0, 3'd5, 3'd0);
      step();
      drive(5'b00000, 3'd2, 32'd0, 32'd0, 3'd5, 3'd0);
      step();
      drive(5'b00000, 3'd3, 32'd0, 32'd3, 3'd6, 3'd0);
      step();
      idle();
      mem_num   = 3'd5;
      mem_value = 32'd0;
      step();
      idle();
      step();
      check_eq("order_a_num", {29'd0, alu_num}, 32'd1);
      step();
      check_eq("order_b_num", {29'd0, alu_num}, 32'd2);
      drive(5'b00000, 3'd4, 32'd1, 32'd1, 3'd0, 3'd0);
      mem_num   = 3'd6;
      mem_value = 32'd2;
      step();
      idle();
`ifdef RS_AGE_SELECT_EN
      first_tag  = 3'd3;
      first_val  = 32'd5;
      second_tag = 3'd4;
      second_val = 32'd2;
`else
      first_tag  = 3'd4;
      first_val  = 32'd2;
      second_tag = 3'd3;
      second_val = 32'd5;
`endif
      step();
      check_eq("order_first_num", {29'd0, alu_num}, {29'd0, first_tag});
      check_eq("order_first_value", alu_value, first_val);
      step();
      check_eq("order_second_num", {29'd0, alu_num}, {29'd0, second_tag});
      check_eq("order_second_value", alu_value, second_val);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/reservation_station.md
RESERVATION_STATION -- requirements
Module: reservation_station

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning number of entries; legal values 2..8.
REQ-002 SHALL have ports: clk  in  1  sole clock, all state changes on posedge; rst  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have ports: op_in  in  5  dispatched op, 5'b11111 = none; target_in  in  3  ROB tag of result, 1..7.
REQ-004 SHALL have ports: value1_in, value2_in  in  32 each  operand values; query1_in, query2_in  in  3 each  producer tag, 0 = value valid.
REQ-005 SHALL have ports: mem_num  in  3  load broadcast tag, 0 = none; mem_value  in  32  load broadcast data.
REQ-006 SHALL have ports: rs_full  out  1  all entries valid; alu_num  out  3  result tag, 0 = none; alu_value  out  32  result data.

Function
REQ-007 SHALL accept ops ADD 00000, AND 00001, OR 00010, SLL 00011, SRL 00100, SLT 00101, SLTU 00110, SRA 00111, SUB 01000, XOR 01001, BEQ 01010, BGE 01011, BNE 01100, BGEU 01101, BLT 11010, BLTU 11011 and JALR 10001.
REQ-008 SHALL silently drop every other op_in value, including 11111; no entry written.
REQ-009 SHALL write a dispatch at posedge when op_in is accepted and rs_full is low, into the lowest-index free entry.
REQ-010 SHALL drop a dispatch presented while rs_full is high, even if an issue frees a slot on the same edge.
REQ-011 SHALL drive rs_full combinationally from entry valid bits, high iff all DEPTH entries are valid.
REQ-012 SHALL wake operands each posedge: any valid entry with queryX == mem_num (nonzero) captures mem_value and clears queryX.
REQ-013 SHALL apply the same wakeup from its own registered alu_num/alu_value pair.
REQ-014 SHALL apply wakeup to an entry being dispatched on the same edge: an incoming queryX matching mem_num or alu_num captures that value.
REQ-015 SHALL, if mem_num == alu_num (nonzero), take mem_value.
REQ-016 SHALL treat an entry as ready when valid with query1 == 0 and query2 == 0 before the edge.
REQ-017 SHALL issue at most one ready entry per posedge: compute, free the entry, register alu_num = its tag and alu_value = its result.
REQ-018 SHALL drive alu_num = 0 on any edge with no issue; alu_value then holds its previous value.
REQ-019 SHALL give minimum latency of one cycle: a ready dispatch at edge N appears on alu_num/alu_value after edge N+1.
REQ-020 SHALL compute 32-bit wrap-around ADD/SUB; shifts use value2[4:0]; SLT/BGE/BLT signed; SLTU/BGEU/BLTU unsigned.
REQ-021 SHALL make SLT/SLTU results 0 or 1.
REQ-022 SHALL make branch results 32'd1 if taken and 32'd0 if not taken.
REQ-023 SHALL make the JALR result (value1 + value2) & 32'hFFFFFFFE.

Reset
REQ-024 SHALL, while rst is low, asynchronously clear all valid bits; rs_full = 0, alu_num = 0, alu_value = 0.
REQ-025 SHALL discard in-flight entries and a pending result on reset mid-operation; first dispatch is accepted on the first posedge after rst rises.

Configuration
REQ-026 SHALL, with RS_AGE_SELECT_EN defined, keep per-entry age order and issue the oldest ready entry.
REQ-027 SHALL, without RS_AGE_SELECT_EN, issue the lowest-index ready entry; no age state implemented.

Verification
REQ-028 SHALL cover: dispatch ADD tag 3, values 5 and 7, queries 0 -> next cycle alu_num = 3, alu_value = 12; following cycle alu_num = 0.
REQ-029 SHALL cover: dispatch SUB tag 2, query1 = 5, value2 = 1; two edges later mem_num = 5, mem_value = 10 -> one cycle after that alu_num = 2, alu_value = 9.
REQ-030 SHALL cover: fill 4 entries all waiting on tag 6 -> rs_full = 1; fifth dispatch dropped; mem_num = 6 -> four results issued over four consecutive cycles, then rs_full = 0.
REQ-031 SHALL cover: BLT 0xFFFFFFFF vs 1 -> alu_value = 1; BLTU same operands -> alu_value = 0; JALR 0x1001 + 4 -> alu_value = 0x1004.
REQ-032 SHALL cover: dispatch with query1 = 4 on the same edge mem_num = 4, mem_value = 20, op ADD, value2 = 1 -> next cycle alu_value = 21.
REQ-033 SHALL cover: rst low for one cycle with 3 entries valid -> alu_num = 0, rs_full = 0, no stale result after release.
REQ-034 SHALL cover, with RS_AGE_SELECT_EN: entry in slot 2 ready earlier than slot 0 -> slot 2 issues first.
